// File: rtl/dcache_mem_stage.sv
// dcache_mem_stage: direct-mapped write-through no-write-allocate MEM-stage data cache; pipeline side (MemReadM/MemWriteM/AddrM/WriteDataM -> ReadDataM/StallM), memory side (mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ready), saturating hit_cnt/miss_cnt
module dcache_mem_stage #(
  parameter int LINES = 16,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemReadM,
  input  logic            MemWriteM,
  input  logic [XLEN-1:0] AddrM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            StallM,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [15:0]     hit_cnt,
  output logic [15:0]     miss_cnt
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;
  state_t state_q, state_d;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [XLEN-1:0] data_q [LINES];
  logic mem_req_q, mem_we_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
  logic [15:0] hit_cnt_q, miss_cnt_q;
  logic [IDX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] tag, ftag;
  logic idle, hit, rd_hit, rd_miss, start, fill, wr_done;
  assign idx = AddrM[IDX_W+1:2];
  assign tag = AddrM[XLEN-1:IDX_W+2];
  assign fidx = mem_addr_q[IDX_W+1:2];
  assign ftag = mem_addr_q[XLEN-1:IDX_W+2];
  assign idle = state_q == IDLE;
  assign hit = MemReadM & valid_q[idx] & (tag_q[idx] == tag);
  assign rd_hit = idle & hit & !MemWriteM;
  assign rd_miss = idle & MemReadM & !MemWriteM & !hit;
  assign start = rd_miss | (idle & MemWriteM);
  assign fill = state_q == RD_MISS && mem_ready;
  assign wr_done = state_q == WR_THRU && mem_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mem_req_q <= 1'b1;
        mem_we_q <= MemWriteM;
        mem_addr_q <= AddrM & ~XLEN'(3);
        if (MemWriteM) mem_wdata_q <= WriteDataM;
      end else if (!idle && mem_ready) begin
        mem_req_q <= 1'b0;
      end
      if (fill) valid_q[fidx] <= 1'b1;
      if (rd_hit && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (rd_miss && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end
  // Tag/data need no reset: valid bits gate every use. The fill and the write-through update index by the latched request address.
  always_ff @(posedge clk) begin
    if (!reset && fill) begin
      tag_q[fidx] <= ftag;
      data_q[fidx] <= mem_rdata;
    end else if (!reset && wr_done && valid_q[fidx] && tag_q[fidx] == ftag) begin
      data_q[fidx] <= mem_wdata_q;
    end
  end
  always_comb begin
    state_d = idle ? (MemWriteM ? WR_THRU : rd_miss ? RD_MISS : IDLE) : mem_ready ? IDLE : state_q;
  end
  always_comb begin
    StallM = idle ? start : !mem_ready;
    ReadDataM = rd_hit ? data_q[idx] : fill ? mem_rdata : '0;
  end
  assign mem_req = mem_req_q;
  assign mem_we = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_dcache_mem_stage.sv
// tb_dcache_mem_stage: per-cycle vector table plus a reset-during-miss sequence
module tb_dcache_mem_stage;
  logic clk = 1'b0, reset = 1'b1, MemReadM = 1'b0, MemWriteM = 1'b0, mem_ready = 1'b0;
  logic [31:0] AddrM = '0, WriteDataM = '0, mem_rdata = '0;
  logic [31:0] ReadDataM, mem_addr, mem_wdata;
  logic StallM, mem_req, mem_we;
  logic [15:0] hit_cnt, miss_cnt;
  int errors = 0, checks = 0;

  dcache_mem_stage dut (
    .clk(clk), .reset(reset), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd, wr;
    logic [31:0] addr, wd;
    logic rdy;
    logic [31:0] rdata;
    logic stall;
    logic [31:0] rdo;
    logic req, we;
    logic [31:0] maddr, mwd;
    logic [15:0] hc, mc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rd, logic wr, logic [31:0] addr, logic [31:0] wd, logic rdy,
                             logic [31:0] rdata, logic stall, logic [31:0] rdo, logic req, logic we,
                             logic [31:0] maddr, logic [31:0] mwd, logic [15:0] hc, logic [15:0] mc);
    vec_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wd = wd; r.rdy = rdy; r.rdata = rdata;
    r.stall = stall; r.rdo = rdo; r.req = req; r.we = we; r.maddr = maddr; r.mwd = mwd;
    r.hc = hc; r.mc = mc;
    return r;
  endfunction

  task automatic chk(string name, int n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  initial begin
    // rd wr addr wd rdy rdata | stall rdo req we maddr mwd hc mc
    tbl.push_back(v(0,0,32'h0,32'h0,0,32'h0,               0,32'h0,0,0,32'h0,32'h0,0,0));
    tbl.push_back(v(1,0,32'h40,32'h0,0,32'h0,              1,32'h0,0,0,32'h0,32'h0,0,0));
    tbl.push_back(v(1,0,32'h40,32'h0,0,32'h0,              1,32'h0,1,0,32'h40,32'h0,0,1));
    tbl.push_back(v(1,0,32'h40,32'h0,0,32'h0,              1,32'h0,1,0,32'h40,32'h0,0,1));
    tbl.push_back(v(1,0,32'h40,32'h0,0,32'h0,              1,32'h0,1,0,32'h40,32'h0,0,1));
    tbl.push_back(v(1,0,32'h40,32'h0,1,32'h12345678,       0,32'h12345678,1,0,32'h40,32'h0,0,1));
    tbl.push_back(v(1,0,32'h40,32'h0,0,32'h0,              0,32'h12345678,0,0,32'h40,32'h0,0,1));
    tbl.push_back(v(0,0,32'h0,32'h0,0,32'h0,               0,32'h0,0,0,32'h40,32'h0,1,1));
    tbl.push_back(v(0,1,32'h40,32'hDEADBEEF,0,32'h0,       1,32'h0,0,0,32'h40,32'h0,1,1));
    tbl.push_back(v(0,1,32'h40,32'hDEADBEEF,0,32'h0,       1,32'h0,1,1,32'h40,32'hDEADBEEF,1,1));
    tbl.push_back(v(0,1,32'h40,32'hDEADBEEF,1,32'h0,       0,32'h0,1,1,32'h40,32'hDEADBEEF,1,1));
    tbl.push_back(v(1,0,32'h40,32'h0,0,32'h0,              0,32'hDEADBEEF,0,1,32'h40,32'hDEADBEEF,1,1));
    tbl.push_back(v(0,1,32'h80,32'h0BADF00D,0,32'h0,       1,32'h0,0,1,32'h40,32'hDEADBEEF,2,1));
    tbl.push_back(v(0,1,32'h80,32'h0BADF00D,1,32'h0,       0,32'h0,1,1,32'h80,32'h0BADF00D,2,1));
    tbl.push_back(v(1,0,32'h80,32'h0,0,32'h0,              1,32'h0,0,1,32'h80,32'h0BADF00D,2,1));
    tbl.push_back(v(1,0,32'h80,32'h0,1,32'h0BADF00D,       0,32'h0BADF00D,1,0,32'h80,32'h0BADF00D,2,2));
    tbl.push_back(v(1,0,32'h80,32'h0,0,32'h0,              0,32'h0BADF00D,0,0,32'h80,32'h0BADF00D,2,2));
    tbl.push_back(v(1,0,32'h40,32'h0,0,32'h0,              1,32'h0,0,0,32'h80,32'h0BADF00D,3,2));
    tbl.push_back(v(1,0,32'h40,32'h0,1,32'h11111111,       0,32'h11111111,1,0,32'h40,32'h0BADF00D,3,3));
    tbl.push_back(v(1,0,32'h440,32'h0,0,32'h0,             1,32'h0,0,0,32'h40,32'h0BADF00D,3,3));
    tbl.push_back(v(1,0,32'h440,32'h0,1,32'h22222222,      0,32'h22222222,1,0,32'h440,32'h0BADF00D,3,4));
    tbl.push_back(v(1,0,32'h40,32'h0,0,32'h0,              1,32'h0,0,0,32'h440,32'h0BADF00D,3,4));
    tbl.push_back(v(1,0,32'h40,32'h0,1,32'h33333333,       0,32'h33333333,1,0,32'h40,32'h0BADF00D,3,5));
    tbl.push_back(v(1,0,32'h40,32'h0,0,32'h0,              0,32'h33333333,0,0,32'h40,32'h0BADF00D,3,5));
    tbl.push_back(v(0,0,32'h0,32'h0,1,32'hFFFFFFFF,        0,32'h0,0,0,32'h40,32'h0BADF00D,4,5));
    tbl.push_back(v(1,1,32'h42,32'h44444444,0,32'h0,       1,32'h0,0,0,32'h40,32'h0BADF00D,4,5));
    tbl.push_back(v(1,1,32'h42,32'h44444444,1,32'h0,       0,32'h0,1,1,32'h40,32'h44444444,4,5));
    tbl.push_back(v(1,0,32'h40,32'h0,0,32'h0,              0,32'h44444444,0,1,32'h40,32'h44444444,4,5));
    tbl.push_back(v(0,0,32'h0,32'h0,0,32'h0,               0,32'h0,0,1,32'h40,32'h44444444,5,5));

    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      MemReadM = tbl[i].rd; MemWriteM = tbl[i].wr; AddrM = tbl[i].addr; WriteDataM = tbl[i].wd;
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].rdata;
      #1;
      chk("stall", i, 32'(StallM), 32'(tbl[i].stall));
      chk("rdata", i, ReadDataM, tbl[i].rdo);
      chk("req", i, 32'(mem_req), 32'(tbl[i].req));
      chk("we", i, 32'(mem_we), 32'(tbl[i].we));
      chk("maddr", i, mem_addr, tbl[i].maddr);
      chk("mwdata", i, mem_wdata, tbl[i].mwd);
      chk("hit_cnt", i, 32'(hit_cnt), 32'(tbl[i].hc));
      chk("miss_cnt", i, 32'(miss_cnt), 32'(tbl[i].mc));
    end

    // Reset in the middle of a read miss; line 0 currently holds 0x40 valid.
    @(negedge clk); MemReadM = 1; MemWriteM = 0; AddrM = 32'h80; mem_ready = 0; #1;
    chk("rst_seq_stall_miss", 100, 32'(StallM), 32'd1);
    @(negedge clk); #1;
    chk("rst_seq_req_busy", 101, 32'(mem_req), 32'd1);
    @(negedge clk); reset = 1; MemReadM = 0;
    @(negedge clk); reset = 0; mem_ready = 1; mem_rdata = 32'hAAAAAAAA; #1;
    chk("rst_req", 102, 32'(mem_req), 32'd0);
    chk("rst_maddr", 103, mem_addr, 32'h0);
    chk("rst_miss_cnt", 104, 32'(miss_cnt), 32'd0);
    chk("rst_hit_cnt", 105, 32'(hit_cnt), 32'd0);
    chk("rst_stall", 106, 32'(StallM), 32'd0);
    chk("rst_rdata", 107, ReadDataM, 32'h0);
    @(negedge clk); mem_ready = 0; #1;
    chk("late_ready_req", 108, 32'(mem_req), 32'd0);
    @(negedge clk); MemReadM = 1; AddrM = 32'h40; #1;
    chk("post_rst_miss_stall", 109, 32'(StallM), 32'd1);
    chk("post_rst_miss_rdata", 110, ReadDataM, 32'h0);
    @(negedge clk); #1;
    chk("post_rst_req", 111, 32'(mem_req), 32'd1);
    chk("post_rst_miss_cnt", 112, 32'(miss_cnt), 32'd1);
    chk("post_rst_we", 113, 32'(mem_we), 32'd0);
    mem_ready = 1; mem_rdata = 32'h55555555; #1;
    chk("post_rst_fill_rdata", 114, ReadDataM, 32'h55555555);
    chk("post_rst_fill_stall", 115, 32'(StallM), 32'd0);
    @(negedge clk); mem_ready = 0; #1;
    chk("post_rst_hit", 116, ReadDataM, 32'h55555555);
    chk("post_rst_req_clr", 117, 32'(mem_req), 32'd0);
    @(negedge clk); MemReadM = 0; #1;
    chk("post_rst_hit_cnt", 118, 32'(hit_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dcache_mem_stage.md
Name: dcache_mem_stage

Overview:
- Direct-mapped, write-through, no-write-allocate data cache for the MEM stage of the 5-stage pipeline.
- Sits between the memory-stage pipeline register outputs (ALUOutM, WriteDataM, MemWriteM, MemtoRegM) and a slow main memory with a req/ready handshake.
- Returns ReadDataM to the MEM/WB register.
- Raises StallM, which the hazard unit ORs into stall of F/D/E/M and a bubble into W, while a miss or write-through is outstanding.

Parameters:
- LINES, 16, number of cache lines (power of two, ≥2); IDX_W = log2(LINES).
- XLEN, 32, data/address width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- MemReadM  input  1  load in MEM stage (driven from MemtoRegM).
- MemWriteM  input  1  store in MEM stage.
- AddrM  input  XLEN  byte address (ALUOutM).
- WriteDataM  input  XLEN  store data.
- ReadDataM  output  XLEN  load result to MEM/WB latch.
- StallM  output  1  pipeline hold request.
- mem_req  output  1  main-memory request, registered.
- mem_we  output  1  1 = write, 0 = read, registered.
- mem_addr  output  XLEN  word-aligned address (bits [1:0] = 0), registered.
- mem_wdata  output  XLEN  store data, registered.
- mem_rdata  input  XLEN  read data, valid when mem_ready = 1.
- mem_ready  input  1  one-cycle completion pulse for the current request.
- hit_cnt  output  16  saturating load-hit counter.
- miss_cnt  output  16  saturating load-miss counter.

Behaviour:
- Address split: index = AddrM[IDX_W+1:2], tag = AddrM[XLEN-1:IDX_W+2], AddrM[1:0] ignored (word accesses only).
- Line storage: valid bit, tag, one XLEN data word per line.
- hit = MemReadM and valid[index] and tag match.
- States:
  - IDLE: no outstanding request.
  - RD_MISS: read outstanding.
  - WR_THRU: write outstanding.
- IDLE, neither MemReadM nor MemWriteM asserted: StallM = 0, ReadDataM = 0, no state change.
- IDLE, read hit: StallM = 0; ReadDataM = line data, combinational, same cycle; hit_cnt += 1.
- IDLE, read miss: StallM = 1 combinationally this cycle.
  - At the edge: latch mem_addr = {AddrM[XLEN-1:2], 2'b00}, mem_we = 0, mem_req = 1; go to RD_MISS; miss_cnt += 1.
- IDLE, MemWriteM (with or without MemReadM; write has priority): StallM = 1.
  - At the edge: latch mem_addr, mem_wdata = WriteDataM, mem_we = 1, mem_req = 1; go to WR_THRU.
- RD_MISS: StallM = !mem_ready; mem_req held high until mem_ready.
  - On the mem_ready cycle: ReadDataM = mem_rdata (bypass); line[index] gets valid = 1, tag, data at the edge; mem_req = 0; go to IDLE.
- WR_THRU: StallM = !mem_ready.
  - On the mem_ready cycle: if the line is valid with matching tag, update its data to mem_wdata at the edge; otherwise no allocate. mem_req = 0; go to IDLE.
- Minimum latencies:
  - Hit: 0 stall cycles.
  - Miss/write: 1 detect cycle plus a wait of N ≥ 1 cycles until mem_ready. With mem_ready on the first cycle mem_req is high, StallM is high for exactly 1 cycle.
- Pipeline inputs are held stable by StallM; the block relatches nothing while busy.
- mem_ready while mem_req = 0 is ignored.
- mem_addr and mem_wdata stay stable for the whole time mem_req = 1.
- Reset, at any time including mid-miss:
  - State → IDLE; all valid bits cleared; mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, hit_cnt = 0, miss_cnt = 0.
  - An in-flight request is abandoned; a late mem_ready is ignored.
  - After reset with no access, StallM = 0 and ReadDataM = 0.
- Counters saturate at 16'hFFFF and do not wrap.
- Index aliasing: addresses differing only in the tag evict each other on a read-miss fill.

Test Plan:
- Reset, then load from 0x0000_0040 with memory returning 0x1234_5678 after 3 cycles → StallM high 4 cycles, ReadDataM = 0x1234_5678 on the ready cycle, miss_cnt = 1.
- Load again from 0x40 → StallM = 0, ReadDataM = 0x1234_5678 the same cycle, hit_cnt = 1, mem_req stays 0.
- Store 0xDEAD_BEEF to 0x40, ready after 2 cycles → mem_we = 1, mem_addr = 0x40, mem_wdata = 0xDEAD_BEEF; a following load from 0x40 hits and returns 0xDEAD_BEEF.
- Store to uncached 0x80 then load 0x80 → no allocate on the store, so the load misses with mem_we = 0 and miss_cnt increments.
- LINES = 16, load 0x40 then 0x440 (same index, different tag) then 0x40 → three misses, the last one re-fetching.
- Assert reset during RD_MISS, then pulse mem_ready → mem_req = 0 after the edge, no line written, and a load from 0x40 misses.
